mem_cycle_ctl: RTL and testbench
================================

Name: mem_cycle_ctl

Overview:
- Sequences main-memory bus cycles for the microcoded core.
- Takes one 8- or 16-bit read/write request from the microsequencer and splits it into one or two byte cycles on the 8-bit data bus.
- Decodes the region (ROM / device / RAM), drives the active-low chip selects, inserts per-region wait states, and generates the RAM write strobe.
- Assembles 16-bit read data little-endian and handshakes completion back with busy/done.

Parameters:
- ADDR_W, 24, bus address width; region decode uses addr[23:20], so ADDR_W must be at least 24.
- ROM_WAIT, 2, wait cycles per ROM byte access (0..15).
- DEV_WAIT, 3, wait cycles per device byte access (0..15).
- RAM_WAIT, 1, wait cycles per RAM byte access (0..15).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- _reset  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- write  in  1  1 = write, 0 = read; sampled with start.
- op_16bit  in  1  1 = two-byte access; sampled with start.
- addr  in  ADDR_W  byte address of the low byte.
- wdata  in  16  write data.
- bus_data_in  in  8  data bus read value.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  write attempted to ROM.
- rdata  out  16  read result.
- bus_addr  out  ADDR_W  current byte address.
- bus_data_out  out  8  write byte.
- bus_data_oe  out  1  drive bus_data_out onto the bus.
- _sel_rom, _sel_dev, _sel_ram  out  1 each  active-low chip selects.
- ram__w  out  1  active-low write strobe.

Behaviour:
- Reset (async, immediate, including mid-transaction): state=IDLE; busy=0, done=0, err=0, rdata=0, bus_addr=0, bus_data_out=0, bus_data_oe=0, all selects=1, ram__w=1.
- Region decode, per byte, from the current byte address:
  - [23:20]==4'h0 → ROM.
  - [23:20]==4'h7 → device.
  - else → RAM.
  - N = that region's wait parameter.
- States: IDLE → SETUP → WAIT (N cycles; skipped if N=0) → XFER → (second byte ? SETUP : DONE) → IDLE.
- IDLE: busy=0, selects inactive, bus_data_oe=0.
  - start=1 at an edge latches addr/wdata/write/op_16bit, clears err, sets busy=1, enters SETUP.
- SETUP / WAIT:
  - bus_addr = byte address; the selected region's select = 0.
  - On writes: bus_data_oe=1 and bus_data_out = wdata[7:0] for byte 0, wdata[15:8] for byte 1.
  - Wait counter loads N on entry to SETUP and decrements in WAIT.
- XFER, read: bus_data_in is captured at the end of the cycle.
  - Byte 0 goes to rdata[7:0]; on 8-bit reads rdata[15:8] is cleared.
  - Byte 1 goes to rdata[15:8].
- XFER, write: select held, data held, ram__w=0 for exactly this cycle.
  - Exception: a ROM byte suppresses ram__w and sets err=1.
- Second byte (op_16bit=1): bus_addr = addr+1 modulo 2^ADDR_W (wraps all-ones → 0). Region and N are re-decoded, so a byte may cross a region boundary.
- DONE: done=1 and busy=0 in the same cycle, all bus outputs idle; next state IDLE.
  - start asserted during DONE is ignored.
  - The earliest new acceptance is the edge ending the first IDLE cycle.
- Latency, counted in cycles after the accepting edge until the done-high cycle:
  - 8-bit: N+3.
  - 16-bit: N0+N1+5.
- rdata holds its value until the next read XFER overwrites it; writes do not alter rdata.
- err is sticky until the next accepted start.
- Inputs other than bus_data_in are ignored while busy.

Test Plan:
- Reset mid-write: assert _reset=0 during XFER of a RAM write → ram__w, selects and bus_data_oe return to 1/1/0 without waiting for a clock; busy=0.
- 8-bit ROM read: addr=0x000010, bus_data_in=0xA5, defaults → _sel_rom low 4 cycles, done at cycle 5, rdata=0x00A5, err=0.
- 16-bit RAM write: addr=0x100020, wdata=0xBEEF → ram__w low once with bus_data_out=0xEF at 0x100020, then once with 0xBE at 0x100021; done at cycle 7.
- 16-bit read crossing a region: addr=0x0FFFFF with low byte 0x34 (ROM) and high byte 0x12 (RAM) → _sel_rom then _sel_ram, rdata=0x1234, done at cycle 2+1+5=8.
- ROM write: write=1, addr=0x000000 → ram__w never low, err=1 at done, err cleared by the next start.
- Address wrap and start gating:
  - 16-bit read at addr=0xFFFFFF → second byte at 0x000000 (ROM).
  - start held high continuously → the next transaction is accepted only after one IDLE cycle following done.

Source files
------------

// File: rtl/mem_cycle_ctl.sv
// Purpose : sequences 8/16-bit core memory requests as one or two byte cycles on an 8-bit bus,
//           with region decode (ROM/device/RAM), active-low selects, wait states and RAM write strobe.
// Latency : done pulses N+3 cycles after acceptance (8-bit), N0+N1+5 (16-bit); no backpressure,
//           start is only sampled in IDLE and requests arriving while busy or during done are dropped.
//
// Ports:
//   clk, _reset                 clock, asynchronous active-low reset
//   start, write, op_16bit      request strobe and attributes (sampled in IDLE only)
//   addr, wdata                 byte address of the low byte, write data
//   bus_data_in                 read data from the bus
//   busy, done, err, rdata      handshake, sticky ROM-write error, assembled read data
//   bus_addr, bus_data_out,
//   bus_data_oe                 byte address and write byte driven to the bus
//   _sel_rom/_sel_dev/_sel_ram  active-low chip selects
//   ram__w                      active-low write strobe
module mem_cycle_ctl #(
    parameter int ADDR_W   = 24,
    parameter int ROM_WAIT = 2,
    parameter int DEV_WAIT = 3,
    parameter int RAM_WAIT = 1
) (
    input  logic              clk,
    input  logic              _reset,
    input  logic              start,
    input  logic              write,
    input  logic              op_16bit,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    input  logic [7:0]        bus_data_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       rdata,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [7:0]        bus_data_out,
    output logic              bus_data_oe,
    output logic              _sel_rom,
    output logic              _sel_dev,
    output logic              _sel_ram,
    output logic              ram__w
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT,
        S_XFER,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        R_ROM,
        R_DEV,
        R_RAM
    } region_t;

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   base_addr_q;
    logic [15:0]         wdata_q;
    logic                write_q;
    logic                op16_q;
    logic                byte_hi_q;
    logic [3:0]          cnt_q;

    logic [ADDR_W-1:0]   cur_addr;
    region_t             region;
    logic [3:0]          n_wait;

    // Address of the byte currently on the bus; the +1 wraps naturally at ADDR_W bits.
    assign cur_addr = base_addr_q + ADDR_W'(byte_hi_q);

    // Region and wait count are decoded per byte, so the second byte may land in another region.
    always_comb begin
        region = R_RAM;
        n_wait = 4'(RAM_WAIT);
        if (cur_addr[23:20] == 4'h0) begin
            region = R_ROM;
            n_wait = 4'(ROM_WAIT);
        end else if (cur_addr[23:20] == 4'h7) begin
            region = R_DEV;
            n_wait = 4'(DEV_WAIT);
        end
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        busy         = 1'b0;
        done         = 1'b0;
        bus_addr     = '0;
        bus_data_out = 8'h00;
        bus_data_oe  = 1'b0;
        _sel_rom     = 1'b1;
        _sel_dev     = 1'b1;
        _sel_ram     = 1'b1;
        ram__w       = 1'b1;

        // Address, select and write data stay stable from SETUP through XFER of each byte.
        if (state_q == S_SETUP || state_q == S_WAIT || state_q == S_XFER) begin
            busy     = 1'b1;
            bus_addr = cur_addr;
            _sel_rom = (region != R_ROM);
            _sel_dev = (region != R_DEV);
            _sel_ram = (region != R_RAM);
            if (write_q) begin
                bus_data_oe  = 1'b1;
                bus_data_out = byte_hi_q ? wdata_q[15:8] : wdata_q[7:0];
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                state_d = (n_wait == 4'd0) ? S_XFER : S_WAIT;
            end
            S_WAIT: begin
                // Counter holds the remaining wait cycles including this one.
                if (cnt_q <= 4'd1) begin
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                // ROM is never strobed; the attempt is flagged through err instead.
                if (write_q && region != R_ROM) begin
                    ram__w = 1'b0;
                end
                state_d = (op16_q && !byte_hi_q) ? S_SETUP : S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            base_addr_q <= '0;
            wdata_q     <= 16'h0000;
            write_q     <= 1'b0;
            op16_q      <= 1'b0;
            byte_hi_q   <= 1'b0;
            cnt_q       <= 4'd0;
            rdata       <= 16'h0000;
            err         <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        base_addr_q <= addr;
                        wdata_q     <= wdata;
                        write_q     <= write;
                        op16_q      <= op_16bit;
                        byte_hi_q   <= 1'b0;
                        err         <= 1'b0;
                    end
                end
                S_SETUP: begin
                    cnt_q <= n_wait;
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                end
                S_XFER: begin
                    if (write_q) begin
                        if (region == R_ROM) begin
                            err <= 1'b1;
                        end
                    end else if (byte_hi_q) begin
                        rdata[15:8] <= bus_data_in;
                    end else begin
                        // Low byte of a 16-bit read keeps the upper half; it is overwritten next.
                        rdata <= {(op16_q ? rdata[15:8] : 8'h00), bus_data_in};
                    end
                    if (op16_q && !byte_hi_q) begin
                        byte_hi_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_cycle_ctl.sv
module tb_mem_cycle_ctl;

    logic        clk;
    logic        _reset;
    logic        start;
    logic        write;
    logic        op_16bit;
    logic [23:0] addr;
    logic [15:0] wdata;
    logic [7:0]  bus_data_in;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] rdata;
    logic [23:0] bus_addr;
    logic [7:0]  bus_data_out;
    logic        bus_data_oe;
    logic        _sel_rom;
    logic        _sel_dev;
    logic        _sel_ram;
    logic        ram__w;

    mem_cycle_ctl #(
        .ADDR_W   (24),
        .ROM_WAIT (2),
        .DEV_WAIT (3),
        .RAM_WAIT (1)
    ) dut (
        .clk          (clk),
        ._reset       (_reset),
        .start        (start),
        .write        (write),
        .op_16bit     (op_16bit),
        .addr         (addr),
        .wdata        (wdata),
        .bus_data_in  (bus_data_in),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .rdata        (rdata),
        .bus_addr     (bus_addr),
        .bus_data_out (bus_data_out),
        .bus_data_oe  (bus_data_oe),
        ._sel_rom     (_sel_rom),
        ._sel_dev     (_sel_dev),
        ._sel_ram     (_sel_ram),
        .ram__w       (ram__w)
    );

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          lat;
        int          rom;
        int          dev;
        int          ram;
        int          gap;
    } exp_t;

    typedef struct {
        logic [23:0] a;
        logic [7:0]  d;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wr_q[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Bus read model: the low-byte address returns b0_r, any other address b1_r.
    logic [23:0] lo_a;
    logic [7:0]  b0_r;
    logic [7:0]  b1_r;
    assign bus_data_in = (bus_addr == lo_a) ? b0_r : b1_r;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: tracks acceptance, per-transaction select counts, write strobes and completions.
    int   accept_cyc    = 0;
    int   last_done_cyc = -1000;
    int   cur_gap       = 0;
    int   n_rom         = 0;
    int   n_dev         = 0;
    int   n_ram         = 0;
    logic busy_prev     = 1'b0;

    always @(negedge clk) begin
        if (busy && !busy_prev) begin
            accept_cyc = cyc;
            cur_gap    = cyc - last_done_cyc;
            n_rom      = 0;
            n_dev      = 0;
            n_ram      = 0;
            chk("err_clear_on_accept", {31'd0, err}, 32'd0);
        end
        if (!_sel_rom) n_rom++;
        if (!_sel_dev) n_dev++;
        if (!_sel_ram) n_ram++;

        if (!ram__w) begin
            if (wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0h data %0h", bus_addr, bus_data_out);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                chk("write_addr", {8'd0, bus_addr}, {8'd0, w.a});
                chk("write_data", {24'd0, bus_data_out}, {24'd0, w.d});
                chk("write_oe", {31'd0, bus_data_oe}, 32'd1);
            end
        end

        if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: rdata %0h", rdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rdata", {16'd0, rdata}, {16'd0, e.rdata});
                chk("err", {31'd0, err}, {31'd0, e.err});
                chk("latency", cyc - accept_cyc + 1, e.lat);
                chk("rom_sel_cycles", n_rom, e.rom);
                chk("dev_sel_cycles", n_dev, e.dev);
                chk("ram_sel_cycles", n_ram, e.ram);
                chk("busy_at_done", {31'd0, busy}, 32'd0);
                if (e.gap >= 0) chk("accept_gap", cur_gap, e.gap);
            end
            last_done_cyc = cyc;
        end
        busy_prev = busy;
    end

    task automatic wait_done();
        for (int i = 0; i < 100; i++) begin
            if (done) return;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL done_timeout: got no done expected done within 100 cycles");
    endtask

    task automatic drive(input logic wr, input logic op16, input logic [23:0] a,
                         input logic [15:0] wd, input logic [7:0] b0, input logic [7:0] b1);
        write    = wr;
        op_16bit = op16;
        addr     = a;
        wdata    = wd;
        lo_a     = a;
        b0_r     = b0;
        b1_r     = b1;
        start    = 1'b1;
    endtask

    task automatic run_txn(input logic wr, input logic op16, input logic [23:0] a,
                           input logic [15:0] wd, input logic [7:0] b0, input logic [7:0] b1);
        @(negedge clk);
        drive(wr, op16, a, wd, b0, b1);
        @(negedge clk);
        start = 1'b0;
        wait_done();
    endtask

    initial begin
        _reset   = 1'b0;
        start    = 1'b0;
        write    = 1'b0;
        op_16bit = 1'b0;
        addr     = 24'h0;
        wdata    = 16'h0;
        lo_a     = 24'h0;
        b0_r     = 8'h00;
        b1_r     = 8'h00;

        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rdata", {16'd0, rdata}, 32'd0);
        chk("rst_bus_addr", {8'd0, bus_addr}, 32'd0);
        chk("rst_sels", {29'd0, _sel_rom, _sel_dev, _sel_ram}, 32'h7);
        chk("rst_ram_w", {31'd0, ram__w}, 32'd1);
        _reset = 1'b1;

        // Reset asserted during the XFER cycle of a RAM write.
        wr_q.push_back('{a: 24'h100000, d: 8'h55});
        @(negedge clk);
        drive(1'b1, 1'b0, 24'h100000, 16'h0055, 8'h00, 8'h00);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!ram__w) break;
            @(negedge clk);
        end
        #2 _reset = 1'b0;
        #1;
        chk("midrst_ram_w", {31'd0, ram__w}, 32'd1);
        chk("midrst_sel_ram", {31'd0, _sel_ram}, 32'd1);
        chk("midrst_oe", {31'd0, bus_data_oe}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        #2 _reset = 1'b1;

        // 8-bit ROM read
        exp_q.push_back('{rdata: 16'h00A5, err: 1'b0, lat: 5, rom: 4, dev: 0, ram: 0, gap: -1});
        run_txn(1'b0, 1'b0, 24'h000010, 16'h0000, 8'hA5, 8'h00);

        // 16-bit RAM write, rdata left untouched
        wr_q.push_back('{a: 24'h100020, d: 8'hEF});
        wr_q.push_back('{a: 24'h100021, d: 8'hBE});
        exp_q.push_back('{rdata: 16'h00A5, err: 1'b0, lat: 7, rom: 0, dev: 0, ram: 6, gap: -1});
        run_txn(1'b1, 1'b1, 24'h100020, 16'hBEEF, 8'h00, 8'h00);

        // 16-bit read crossing ROM -> RAM
        exp_q.push_back('{rdata: 16'h1234, err: 1'b0, lat: 8, rom: 4, dev: 0, ram: 3, gap: -1});
        run_txn(1'b0, 1'b1, 24'h0FFFFF, 16'h0000, 8'h34, 8'h12);

        // ROM write: no strobe, sticky err
        exp_q.push_back('{rdata: 16'h1234, err: 1'b1, lat: 5, rom: 4, dev: 0, ram: 0, gap: -1});
        run_txn(1'b1, 1'b0, 24'h000000, 16'h00C3, 8'h00, 8'h00);
        @(negedge clk);
        chk("err_sticky_idle", {31'd0, err}, 32'd1);

        // 16-bit read wrapping from all-ones to ROM address 0
        exp_q.push_back('{rdata: 16'h5678, err: 1'b0, lat: 8, rom: 4, dev: 0, ram: 3, gap: -1});
        run_txn(1'b0, 1'b1, 24'hFFFFFF, 16'h0000, 8'h78, 8'h56);

        // 8-bit device write, strobed
        wr_q.push_back('{a: 24'h700005, d: 8'h22});
        exp_q.push_back('{rdata: 16'h5678, err: 1'b0, lat: 6, rom: 0, dev: 5, ram: 0, gap: -1});
        run_txn(1'b1, 1'b0, 24'h700005, 16'h1122, 8'h00, 8'h00);

        // start held high: second acceptance only after one IDLE cycle
        exp_q.push_back('{rdata: 16'h009A, err: 1'b0, lat: 6, rom: 0, dev: 5, ram: 0, gap: -1});
        exp_q.push_back('{rdata: 16'h009A, err: 1'b0, lat: 6, rom: 0, dev: 5, ram: 0, gap: 2});
        @(negedge clk);
        drive(1'b0, 1'b0, 24'h700001, 16'h0000, 8'h9A, 8'h00);
        @(negedge clk);
        wait_done();
        @(negedge clk);
        wait_done();
        start = 1'b0;

        repeat (4) @(negedge clk);
        chk("exp_queue_drained", exp_q.size(), 0);
        chk("wr_queue_drained", wr_q.size(), 0);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
